// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared size encodings, FSM states and IO window constant
package mem_port_arbiter_pkg;
  localparam logic [1:0] MEM_B = 2'd0;
  localparam logic [1:0] MEM_H = 2'd1;
  localparam logic [1:0] MEM_W = 2'd2;
  localparam logic [1:0] IO_HI_DEF = 2'b11;
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  function automatic logic [1:0] last_byte(input logic [1:0] size);
    return size == MEM_W ? 2'd3 : size == MEM_H ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/mem_port_arbiter_port_arb_select.sv
// port_arb_select: fixed-priority or round-robin one-hot grant selection
module port_arb_select #(
  parameter int N_PORTS = 2,
  parameter bit ARB_MODE = 1'b0
) (
  input  logic [N_PORTS-1:0] req_valid,
  input  logic [1:0]         rr_ptr,
  output logic [N_PORTS-1:0] grant,
  output logic [1:0]         idx,
  output logic               any
);
  int j;
  always_comb begin
    j = 0;
    idx = '0;
    any = 1'b0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      j = ARB_MODE ? (int'(rr_ptr) + i) % N_PORTS : i;
      if (|(req_valid & (N_PORTS'(1) << j))) begin
        idx = 2'(j);
        any = 1'b1;
      end
    end
    grant = any ? N_PORTS'(1) << idx : '0;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: multi-port byte-serial RAM/IO bus arbiter with sized, sign-extending accesses
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int         N_PORTS    = 2,
  parameter bit         ARB_MODE   = 1'b0,
  parameter logic [3:0] CLEAR_MASK = 4'b0011,
  parameter logic [1:0] IO_HI      = IO_HI_DEF
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   clear,
  input  logic [N_PORTS-1:0]     req_valid,
  input  logic [32*N_PORTS-1:0]  req_addr,
  input  logic [N_PORTS-1:0]     req_wr,
  input  logic [2*N_PORTS-1:0]   req_size,
  input  logic [N_PORTS-1:0]     req_sext,
  input  logic [32*N_PORTS-1:0]  req_wdata,
  output logic [N_PORTS-1:0]     req_ready,
  output logic [N_PORTS-1:0]     resp_valid,
  output logic [31:0]            resp_data,
  input  logic [7:0]             mem_din,
  output logic [7:0]             mem_dout,
  output logic [31:0]            mem_a,
  output logic                   mem_wr,
  input  logic                   io_buffer_full
);
  state_t state;
  logic [1:0] rr_ptr, win, port, cnt, last, w_size, w_last;
  logic [N_PORTS-1:0] grant;
  logic any, fin, sext, w_wr, w_sext, w_io, stall;
  logic [31:0] addr, wdata, asm_q, w_addr, w_wdata, raw;
  port_arb_select #(.N_PORTS(N_PORTS), .ARB_MODE(ARB_MODE)) u_sel (
    .req_valid(req_valid),
    .rr_ptr(rr_ptr),
    .grant(grant),
    .idx(win),
    .any(any)
  );
  always_comb begin
    w_addr = '0;
    w_wdata = '0;
    w_size = '0;
    w_wr = 1'b0;
    w_sext = 1'b0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (win == 2'(p)) begin
        w_addr = req_addr[32*p +: 32];
        w_wdata = req_wdata[32*p +: 32];
        w_size = req_size[2*p +: 2];
        w_wr = req_wr[p];
        w_sext = req_sext[p];
      end
    end
    w_io = w_addr[17:16] == IO_HI;
    w_last = last_byte((!w_wr && w_io) ? MEM_B : w_size);
  end
  assign stall = addr[17:16] == IO_HI && io_buffer_full;
  assign raw = asm_q | (32'(mem_din) << {last, 3'b000});
  assign resp_data = (state == READ && fin) ?
                     (last == 2'd0 ? {{24{sext & raw[7]}}, raw[7:0]} :
                      last == 2'd1 ? {{16{sext & raw[15]}}, raw[15:0]} : raw) : '0;
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state <= IDLE;
      rr_ptr <= '0;
      port <= '0;
      cnt <= '0;
      last <= '0;
      fin <= 1'b0;
      sext <= 1'b0;
      addr <= '0;
      wdata <= '0;
      asm_q <= '0;
      req_ready <= '0;
      resp_valid <= '0;
      mem_a <= '0;
      mem_dout <= '0;
      mem_wr <= 1'b0;
    end else if (rdy_in) begin
      req_ready <= '0;
      resp_valid <= '0;
      case (state)
        IDLE: begin
          if (any && !clear) begin
            state <= w_wr ? WRITE : READ;
            req_ready <= grant;
            port <= win;
            addr <= w_addr;
            wdata <= w_wdata;
            sext <= w_sext;
            last <= w_last;
            cnt <= '0;
            fin <= 1'b0;
            asm_q <= '0;
            mem_a <= w_addr;
            mem_dout <= w_wr ? w_wdata[7:0] : 8'd0;
            mem_wr <= w_wr && !(w_io && io_buffer_full);
            if (ARB_MODE) rr_ptr <= (win == 2'(N_PORTS - 1)) ? 2'd0 : win + 2'd1;
          end
        end
        READ: begin
          if (fin) begin
            state <= IDLE;
          end else if (clear && CLEAR_MASK[port]) begin
            state <= IDLE;
            mem_a <= '0;
          end else begin
            if (cnt != 2'd0) asm_q[{cnt - 2'd1, 3'b000} +: 8] <= mem_din;
            if (cnt == last) begin
              fin <= 1'b1;
              mem_a <= '0;
              resp_valid <= N_PORTS'(1) << port;
            end else begin
              cnt <= cnt + 2'd1;
              mem_a <= addr + 32'(cnt) + 32'd1;
            end
          end
        end
        WRITE: begin
          if (fin) begin
            state <= IDLE;
          end else if (!mem_wr) begin
            mem_wr <= !stall;
          end else if (cnt == last) begin
            fin <= 1'b1;
            mem_a <= '0;
            mem_dout <= '0;
            mem_wr <= 1'b0;
            resp_valid <= N_PORTS'(1) << port;
          end else begin
            cnt <= cnt + 2'd1;
            mem_a <= addr + 32'(cnt) + 32'd1;
            mem_dout <= wdata[{cnt + 2'd1, 3'b000} +: 8];
            mem_wr <= !stall;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
